// File: rtl/reqrsp_mux_pkg.sv
// ============================================================================
// Module  : reqrsp_mux_pkg
// Brief   : Default reqrsp request/response structs and index-width helper
//           shared by the reqrsp N-to-1 mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reqrsp_mux_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;

    typedef struct packed {
        logic [c_ADDR_W-1:0]   addr;
        logic                  write;
        logic [c_DATA_W-1:0]   data;
        logic [c_DATA_W/8-1:0] strb;
    } reqrsp_q_t;

    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic                error;
    } reqrsp_p_t;

    typedef struct packed {
        reqrsp_q_t q;
        logic      q_valid;
        logic      p_ready;
    } reqrsp_req_t;

    typedef struct packed {
        reqrsp_p_t p;
        logic      p_valid;
        logic      q_ready;
    } reqrsp_rsp_t;

    // A single port still needs a one-bit index to carry through the ID FIFO.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reqrsp_id_fifo.sv
// ============================================================================
// Module  : reqrsp_id_fifo
// Brief   : Synchronous FIFO of port indices; head names the port that owns
//           the next response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reqrsp_id_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reqrsp_mux.sv
// ============================================================================
// Module  : reqrsp_mux
// Brief   : N-to-1 reqrsp mux, round-robin request arbitration with in-order
//           response routing. Define REQRSP_MUX_SPILL_EN to register the
//           master request path through a 2-entry spill register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reqrsp_mux
    import reqrsp_mux_pkg::*;
#(
    parameter int  NR_PORTS   = 2,
    parameter type req_t      = reqrsp_req_t,
    parameter type rsp_t      = reqrsp_rsp_t,
    parameter int  RESP_DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t slv_req_i [NR_PORTS],
    output rsp_t slv_rsp_o [NR_PORTS],
    output req_t mst_req_o,
    input  rsp_t mst_rsp_i
);

    localparam int c_IDX_W = idx_width(NR_PORTS);
    localparam int c_Q_W   = $bits(req_t) - 2;

    typedef logic [c_IDX_W-1:0] idx_t;

    logic [NR_PORTS-1:0] w_valid_vec;
    idx_t                r_rr_ptr;
    logic                r_lock;
    idx_t                r_lock_idx;
    idx_t                w_arb_idx;
    idx_t                w_grant;
    logic                w_found;
    int                  w_cand;
    logic                w_up_valid;
    logic                w_up_ready;
    logic                w_up_hs;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    idx_t                w_head;
    logic                w_pop;

    always_comb begin
        for (int i = 0; i < NR_PORTS; i++) begin
            w_valid_vec[i] = slv_req_i[i].q_valid;
        end
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_arb_idx = r_rr_ptr;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            w_cand = int'(r_rr_ptr) + i;
            if (w_cand >= NR_PORTS) begin
                w_cand = w_cand - NR_PORTS;
            end
            if (!w_found && w_valid_vec[c_IDX_W'(w_cand)]) begin
                w_found   = 1'b1;
                w_arb_idx = c_IDX_W'(w_cand);
            end
        end
    end

    assign w_grant    = r_lock ? r_lock_idx : w_arb_idx;
    assign w_up_valid = ~rst_i & w_valid_vec[w_grant] & ~w_fifo_full;
    assign w_up_hs    = w_up_valid & w_up_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_up_hs) begin
            r_rr_ptr <= (w_grant == c_IDX_W'(NR_PORTS - 1)) ? '0 : w_grant + c_IDX_W'(1);
            r_lock   <= 1'b0;
        end else if (w_up_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
        end
    end

`ifdef REQRSP_MUX_SPILL_EN
    logic             r_a_valid;
    logic [c_Q_W-1:0] r_a_q;
    logic             r_b_valid;
    logic [c_Q_W-1:0] r_b_q;
    logic [c_Q_W-1:0] w_in_q;
    logic             w_out_hs;

    assign w_in_q     = slv_req_i[w_grant].q;
    assign w_up_ready = ~r_b_valid;
    assign w_out_hs   = r_a_valid & mst_rsp_i.q_ready;

    // Slot A drives the master; slot B only fills while A is stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_valid <= 1'b0;
            r_a_q     <= '0;
            r_b_valid <= 1'b0;
            r_b_q     <= '0;
        end else if (w_out_hs) begin
            if (r_b_valid) begin
                r_a_q     <= r_b_q;
                r_b_valid <= 1'b0;
            end else begin
                r_a_valid <= w_up_hs;
                r_a_q     <= w_in_q;
            end
        end else if (!r_a_valid) begin
            r_a_valid <= w_up_hs;
            r_a_q     <= w_in_q;
        end else if (w_up_hs) begin
            r_b_valid <= 1'b1;
            r_b_q     <= w_in_q;
        end
    end
`else
    assign w_up_ready = mst_rsp_i.q_ready;
`endif

    assign w_pop = mst_rsp_i.p_valid & mst_req_o.p_ready;

    reqrsp_id_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (c_IDX_W)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_up_hs),
        .i_data  (w_grant),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        for (int i = 0; i < NR_PORTS; i++) begin
            slv_rsp_o[i] = '0;
            if (!rst_i) begin
                slv_rsp_o[i].p = mst_rsp_i.p;
            end
        end
        slv_rsp_o[w_grant].q_ready = ~rst_i & w_up_ready & ~w_fifo_full;
        if (!rst_i && !w_fifo_empty) begin
            slv_rsp_o[w_head].p_valid = mst_rsp_i.p_valid;
        end

        mst_req_o = '0;
`ifdef REQRSP_MUX_SPILL_EN
        mst_req_o.q       = r_a_q;
        mst_req_o.q_valid = r_a_valid & ~rst_i;
`else
        if (!rst_i) begin
            mst_req_o.q = slv_req_i[w_grant].q;
        end
        mst_req_o.q_valid = w_up_valid;
`endif
        mst_req_o.p_ready = ~rst_i & ~w_fifo_empty & slv_req_i[w_head].p_ready;
    end

    generate
        for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_q_stable
            a_q_stable : assert property (@(posedge clk_i) disable iff (rst_i)
                (slv_req_i[gi].q_valid && !slv_rsp_o[gi].q_ready) |=> $stable(slv_req_i[gi].q));
        end
    endgenerate

    a_rsp_owned : assert property (@(posedge clk_i) disable iff (rst_i)
        mst_rsp_i.p_valid |-> !w_fifo_empty);

endmodule

`default_nettype wire

// File: tb/tb_reqrsp_mux.sv
// ============================================================================
// Module  : tb_reqrsp_mux
// Brief   : Scoreboard bench for reqrsp_mux: reset, fairness, full, routing
//           and lock scenarios with a credit-controlled target model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reqrsp_mux;
    import reqrsp_mux_pkg::*;

    localparam int NP = 4;
`ifdef REQRSP_MUX_SPILL_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    typedef struct {
        logic [15:0] addr;
        bit          chk_gap;
    } req_exp_t;

    typedef struct {
        int          port;
        logic [15:0] data;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    reqrsp_req_t slv_req [NP];
    reqrsp_rsp_t slv_rsp [NP];
    reqrsp_req_t mst_req;
    reqrsp_rsp_t mst_rsp;

    logic        drv_valid [NP];
    logic [15:0] drv_addr  [NP];
    logic        p_rdy     [NP];
    int          issued    [NP];
    int          done_cnt  [NP];
    int          seq       [NP];
    bit          hs_s      [NP];

    logic        tgt_q_ready;
    logic        tgt_p_valid;
    logic [15:0] tgt_data;
    int          tgt_credit;
    int          tgt_used;
    logic [15:0] tgt_q [$];

    req_exp_t    exp_req [$];
    rsp_exp_t    exp_rsp [$];
    req_exp_t    m_req;
    rsp_exp_t    m_rsp;
    int          n_cmp;
    int          n_bad;
    int          hs_cnt;
    int          cyc;
    int          last_hs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            slv_req[i]         = '0;
            slv_req[i].q.addr  = drv_addr[i];
            slv_req[i].q_valid = drv_valid[i];
            slv_req[i].p_ready = p_rdy[i];
        end
        mst_rsp         = '0;
        mst_rsp.q_ready = tgt_q_ready;
        mst_rsp.p_valid = tgt_p_valid;
        mst_rsp.p.data  = tgt_data;
    end

    reqrsp_mux #(
        .NR_PORTS   (NP),
        .req_t      (reqrsp_req_t),
        .rsp_t      (reqrsp_rsp_t),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_req(input int port, input int s, input bit gap);
        logic [15:0] a;
        a = 16'((port << 12) | s);
        exp_req.push_back('{addr: a, chk_gap: gap});
        exp_rsp.push_back('{port: port, data: ~a});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL idle_timeout: pending req %0d rsp %0d, required 0 0",
                     exp_req.size(), exp_rsp.size());
        end
        repeat (2) step();
    endtask

    // Upstream port drivers: each port walks its own sequence numbers.
    initial begin
        for (int i = 0; i < NP; i++) begin
            drv_valid[i] = 1'b0;
            drv_addr[i]  = 16'(i << 12);
            done_cnt[i]  = 0;
            seq[i]       = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                hs_s[i] = drv_valid[i] && slv_rsp[i].q_ready;
            end
            @(posedge clk);
            #2;
            for (int i = 0; i < NP; i++) begin
                if (hs_s[i]) begin
                    done_cnt[i]++;
                    seq[i]++;
                end
                drv_valid[i] = (issued[i] - done_cnt[i]) > 0;
                drv_addr[i]  = 16'((i << 12) | seq[i]);
            end
        end
    end

    // Downstream target: answers each accepted request with ~addr, gated by credit.
    initial begin
        bit          qh;
        bit          ph;
        logic [15:0] qa;
        tgt_p_valid = 1'b0;
        tgt_data    = '0;
        tgt_used    = 0;
        forever begin
            @(negedge clk);
            qh = mst_req.q_valid && tgt_q_ready;
            ph = tgt_p_valid && mst_req.p_ready;
            qa = mst_req.q.addr;
            @(posedge clk);
            #2;
            if (rst) begin
                tgt_q.delete();
            end else begin
                if (ph) begin
                    void'(tgt_q.pop_front());
                    tgt_used++;
                end
                if (qh) tgt_q.push_back(~qa);
            end
            tgt_p_valid = (tgt_q.size() > 0) && (tgt_used < tgt_credit);
            tgt_data    = (tgt_q.size() > 0) ? tgt_q[0] : 16'h0;
        end
    end

    // Monitor: pops the scoreboard on every master request and slave response handshake.
    initial begin
        last_hs = 0;
        hs_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mst_req.q_valid && mst_rsp.q_ready) begin
                    hs_cnt++;
                    if (exp_req.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mst_req_unexpected: got addr %h, required none", mst_req.q.addr);
                    end else begin
                        m_req = exp_req.pop_front();
                        chk("mst_req_addr", 32'(mst_req.q.addr), 32'(m_req.addr));
                        if (m_req.chk_gap) chk("mst_req_gap", 32'(cyc - last_hs), 32'd1);
                    end
                    last_hs = cyc;
                end
                for (int i = 0; i < NP; i++) begin
                    if (slv_rsp[i].p_valid && p_rdy[i]) begin
                        if (exp_rsp.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL slv_rsp_unexpected: got port %0d, required none", i);
                        end else begin
                            m_rsp = exp_rsp.pop_front();
                            chk("rsp_port", 32'(i), 32'(m_rsp.port));
                            chk("rsp_data", 32'(slv_rsp[i].p.data), 32'(m_rsp.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic any_qr;
        logic any_pv;
        int   h0;
        n_cmp       = 0;
        n_bad       = 0;
        tgt_q_ready = 1'b1;
        tgt_credit  = 0;
        for (int i = 0; i < NP; i++) begin
            p_rdy[i]  = 1'b1;
            issued[i] = 0;
        end

        // Reset with all ports requesting, then fairness 0,1,2,3,0.
        expect_req(0, 0, 1'b0);
        expect_req(1, 0, 1'b1);
        expect_req(2, 0, 1'b1);
        expect_req(3, 0, 1'b1);
        expect_req(0, 1, 1'b1);
        issued[0]  = 2;
        issued[1]  = 1;
        issued[2]  = 1;
        issued[3]  = 1;
        tgt_credit = 5;
        repeat (3) begin
            @(negedge clk);
            any_qr = 1'b0;
            any_pv = 1'b0;
            for (int i = 0; i < NP; i++) begin
                any_qr = any_qr | slv_rsp[i].q_ready;
                any_pv = any_pv | slv_rsp[i].p_valid;
            end
            chk("rst_mst_q_valid", 32'(mst_req.q_valid), 32'd0);
            chk("rst_slv_q_ready", 32'(any_qr), 32'd0);
            chk("rst_slv_p_valid", 32'(any_pv), 32'd0);
        end
        step();
        rst = 1'b0;
        wait_idle();

        // Full: target silent, exactly DEPTH accepted; one response frees one slot.
        for (int k = 1; k <= DEPTH + 1; k++) expect_req(1, k, 1'b0);
        issued[1] += DEPTH + 1;
        h0 = hs_cnt;
        repeat (12) step();
        @(negedge clk);
        chk("full_accepted", 32'(hs_cnt - h0), 32'(DEPTH));
        chk("full_q_ready", 32'(slv_rsp[1].q_ready), 32'd0);
        chk("full_mst_q_valid", 32'(mst_req.q_valid), 32'd0);
        step();
        tgt_credit += 1;
        repeat (8) step();
        @(negedge clk);
        chk("full_one_slot", 32'(hs_cnt - h0), 32'(DEPTH + 1));
        step();
        tgt_credit += DEPTH;
        wait_idle();

        // Routing: port 1 then port 3; port 1 stalls its response, port 3 must wait.
        expect_req(1, DEPTH + 2, 1'b0);
        expect_req(3, 1, 1'b0);
        issued[1] += 1;
        repeat (3) step();
        issued[3] += 1;
        repeat (4) step();
        p_rdy[1] = 1'b0;
        tgt_credit += 2;
        repeat (2) step();
        repeat (3) begin
            @(negedge clk);
            chk("route_p_valid1", 32'(slv_rsp[1].p_valid), 32'd1);
            chk("route_p_valid3", 32'(slv_rsp[3].p_valid), 32'd0);
            chk("route_mst_p_ready", 32'(mst_req.p_ready), 32'd0);
            step();
        end
        p_rdy[1] = 1'b1;
        wait_idle();

        // Lock: port 2 stalled at the master, port 0 arrives with the pointer at 0.
        expect_req(2, 1, 1'b0);
        expect_req(0, 2, 1'b0);
        tgt_credit += 2;
        tgt_q_ready = 1'b0;
        issued[2] += 1;
        repeat (2) step();
        issued[0] += 1;
        step();
        repeat (5) begin
            @(negedge clk);
            chk("lock_addr", 32'(mst_req.q.addr), 32'h2001);
            chk("lock_valid", 32'(mst_req.q_valid), 32'd1);
            step();
        end
        tgt_q_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
